// File: rtl/lifo_pkg.sv
// rtl/lifo_pkg.sv - shared types and helpers for the dual-mode LIFO/FIFO buffer
package lifo_pkg;

  typedef enum logic {MODE_LIFO = 1'b0, MODE_FIFO = 1'b1} lifo_mode_e;

  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/lifo_deque_ram.sv
// rtl/lifo_deque_ram.sv - storage array: one synchronous write port, one asynchronous read port, no reset
module lifo_deque_ram #(
  parameter int DEPTH      = 32,
  parameter int DATA_WIDTH = 32,
  parameter int AW         = $clog2(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  wr_en,
  input  logic [AW-1:0]         wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [AW-1:0]         rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_i) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/lifo_deque.sv
// rtl/lifo_deque.sv - bounded buffer popping newest-first or oldest-first per cycle from shared storage
import lifo_pkg::*;

module lifo_deque #(
  parameter int DEPTH           = 32,
  parameter int DATA_WIDTH      = 32,
  parameter int ALMOST_FULL     = DEPTH - 2,
  parameter int ALMOST_EMPTY    = 2,
  parameter int OUTPUT_REGISTER = 0
) (
  input  logic                          clk_i,
  input  logic                          reset_ni,
  input  logic                          mode_i,
  input  logic                          flush_i,
  input  logic                          push_i,
  input  logic [DATA_WIDTH-1:0]         push_data_i,
  input  logic                          pop_i,
  output logic [DATA_WIDTH-1:0]         pop_data_o,
  output logic                          pop_valid_o,
  output logic                          empty_o,
  output logic                          full_o,
  output logic                          almost_empty_o,
  output logic                          almost_full_o,
  output logic [cnt_width(DEPTH)-1:0]   count_o,
  input  logic                          err_clear_i,
  output logic                          overflow_o,
  output logic                          underflow_o
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_width(DEPTH);
  localparam logic [AW-1:0] PTR_ONE = AW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);

  logic [AW-1:0]         wr_ptr, rd_ptr, top_ptr;
  logic [CW-1:0]         count;
  logic                  is_empty, is_full;
  logic                  push_acc, pop_acc, set_ovf, set_unf;
  logic [AW-1:0]         wr_addr, rd_addr;
  logic [DATA_WIDTH-1:0] rd_data;
  lifo_mode_e            mode;

  assign mode     = lifo_mode_e'(mode_i);
  assign top_ptr  = wr_ptr - PTR_ONE;
  assign is_empty = (count == '0);
  assign is_full  = (count == CW'(DEPTH));

  // Acceptance in priority order: flush, push+pop, push alone, pop alone.
  always_comb begin
    push_acc = 1'b0;
    pop_acc  = 1'b0;
    set_ovf  = 1'b0;
    set_unf  = 1'b0;
    if (!flush_i) begin
      if (push_i && pop_i) begin
        push_acc = 1'b1;
        if (is_empty) set_unf = 1'b1;
        else          pop_acc = 1'b1;
      end else if (push_i) begin
        if (is_full) set_ovf  = 1'b1;
        else         push_acc = 1'b1;
      end else if (pop_i) begin
        if (is_empty) set_unf = 1'b1;
        else          pop_acc = 1'b1;
      end
    end
  end

  // A LIFO push+pop replaces the top word in place instead of moving pointers.
  assign wr_addr = (pop_acc && mode == MODE_LIFO) ? top_ptr : wr_ptr;
  assign rd_addr = (mode == MODE_FIFO) ? rd_ptr : top_ptr;

  lifo_deque_ram #(
    .DEPTH      (DEPTH),
    .DATA_WIDTH (DATA_WIDTH),
    .AW         (AW)
  ) u_ram (
    .clk_i   (clk_i),
    .wr_en   (push_acc),
    .wr_addr (wr_addr),
    .wr_data (push_data_i),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (push_acc && pop_acc) begin
      if (mode == MODE_FIFO) begin
        wr_ptr <= wr_ptr + PTR_ONE;
        rd_ptr <= rd_ptr + PTR_ONE;
      end
    end else if (push_acc) begin
      wr_ptr <= wr_ptr + PTR_ONE;
      count  <= count + CNT_ONE;
    end else if (pop_acc) begin
      if (mode == MODE_FIFO) rd_ptr <= rd_ptr + PTR_ONE;
      else                   wr_ptr <= top_ptr;
      count <= count - CNT_ONE;
    end
  end

  // Setting an error wins over a clear in the same cycle.
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      overflow_o  <= 1'b0;
      underflow_o <= 1'b0;
    end else begin
      overflow_o  <= set_ovf | (overflow_o  & ~err_clear_i);
      underflow_o <= set_unf | (underflow_o & ~err_clear_i);
    end
  end

  generate
    if (OUTPUT_REGISTER != 0) begin : g_out_reg
      logic [DATA_WIDTH-1:0] data_q;
      logic                  valid_q;

      always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
          data_q  <= '0;
          valid_q <= 1'b0;
        end else begin
          valid_q <= pop_acc;
          if (pop_acc) data_q <= rd_data;
        end
      end

      assign pop_data_o  = data_q;
      assign pop_valid_o = valid_q;
    end else begin : g_out_comb
      assign pop_data_o  = rd_data;
      assign pop_valid_o = pop_acc;
    end
  endgenerate

  assign count_o        = count;
  assign empty_o        = is_empty;
  assign full_o         = is_full;
  assign almost_full_o  = (count >= CW'(ALMOST_FULL));
  assign almost_empty_o = (count <= CW'(ALMOST_EMPTY));

endmodule

// File: tb/tb_lifo_deque.sv
// tb/tb_lifo_deque.sv - randomized and directed bench for lifo_deque, both output-register variants
module tb_lifo_deque;

  localparam int DEPTH = 4;
  localparam int DW    = 8;
  localparam int CW    = 3;

  logic          clk_i = 1'b0;
  logic          reset_ni = 1'b0;
  logic          mode_i = 1'b0, flush_i = 1'b0, push_i = 1'b0, pop_i = 1'b0, err_clear_i = 1'b0;
  logic [DW-1:0] push_data_i = '0;

  logic [DW-1:0] a_data, b_data;
  logic          a_valid, b_valid, a_empty, b_empty, a_full, b_full;
  logic          a_ae, b_ae, a_af, b_af, a_ovf, b_ovf, a_unf, b_unf;
  logic [CW-1:0] a_count, b_count;

  always #5 clk_i = ~clk_i;

  lifo_deque #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .OUTPUT_REGISTER(0)) dut_a (
    .clk_i(clk_i), .reset_ni(reset_ni), .mode_i(mode_i), .flush_i(flush_i),
    .push_i(push_i), .push_data_i(push_data_i), .pop_i(pop_i),
    .pop_data_o(a_data), .pop_valid_o(a_valid), .empty_o(a_empty), .full_o(a_full),
    .almost_empty_o(a_ae), .almost_full_o(a_af), .count_o(a_count),
    .err_clear_i(err_clear_i), .overflow_o(a_ovf), .underflow_o(a_unf)
  );

  lifo_deque #(.DEPTH(DEPTH), .DATA_WIDTH(DW), .OUTPUT_REGISTER(1)) dut_b (
    .clk_i(clk_i), .reset_ni(reset_ni), .mode_i(mode_i), .flush_i(flush_i),
    .push_i(push_i), .push_data_i(push_data_i), .pop_i(pop_i),
    .pop_data_o(b_data), .pop_valid_o(b_valid), .empty_o(b_empty), .full_o(b_full),
    .almost_empty_o(b_ae), .almost_full_o(b_af), .count_o(b_count),
    .err_clear_i(err_clear_i), .overflow_o(b_ovf), .underflow_o(b_unf)
  );

  int n_vec = 0;
  int n_err = 0;

  // Reference model: a queue with oldest word at index 0, newest at the back.
  logic [DW-1:0] q[$];
  bit            m_ovf = 0, m_unf = 0, m_rv = 0;
  logic [DW-1:0] m_rd = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_outputs();
    int n = q.size();
    bit pa = !flush_i && pop_i && (n > 0);
    chk("a_count", 32'(a_count), n);
    chk("b_count", 32'(b_count), n);
    chk("a_empty", 32'(a_empty), (n == 0));
    chk("a_full",  32'(a_full),  (n == DEPTH));
    chk("a_almost_full",  32'(a_af), (n >= DEPTH - 2));
    chk("a_almost_empty", 32'(a_ae), (n <= 2));
    chk("b_flags", {28'd0, b_empty, b_full, b_af, b_ae}, {28'd0, (n == 0), (n == DEPTH), (n >= DEPTH - 2), (n <= 2)});
    chk("a_overflow",  32'(a_ovf), m_ovf);
    chk("a_underflow", 32'(a_unf), m_unf);
    chk("b_errs", {30'd0, b_ovf, b_unf}, {30'd0, m_ovf, m_unf});
    chk("a_pop_valid", 32'(a_valid), pa);
    if (n > 0) chk("a_pop_data", 32'(a_data), mode_i ? q[0] : q[$]);
    chk("b_pop_valid", 32'(b_valid), m_rv);
    chk("b_pop_data",  32'(b_data),  m_rd);
  endtask

  task automatic model_edge();
    int n = q.size();
    bit full = (n == DEPTH);
    bit pa = !flush_i && pop_i && (n > 0);
    bit pu = !flush_i && push_i && (!full || pa);
    if (err_clear_i) begin m_ovf = 0; m_unf = 0; end
    if (!flush_i && push_i && !pop_i && full) m_ovf = 1;
    if (!flush_i && pop_i && n == 0) m_unf = 1;
    m_rv = pa;
    if (flush_i) q.delete();
    else begin
      if (pa) m_rd = mode_i ? q.pop_front() : q.pop_back();
      if (pu) q.push_back(push_data_i);
    end
  endtask

  task automatic model_reset();
    q.delete();
    m_ovf = 0; m_unf = 0; m_rv = 0; m_rd = '0;
  endtask

  task automatic apply(input bit push, input logic [DW-1:0] d, input bit pop,
                       input bit mode, input bit flush, input bit clr);
    @(negedge clk_i);
    push_i = push; push_data_i = d; pop_i = pop; mode_i = mode;
    flush_i = flush; err_clear_i = clr;
    #1;
    check_outputs();
    model_edge();
  endtask

  task automatic idle(input bit mode);
    apply(0, '0, 0, mode, 0, 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [DW-1:0] seq  [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    logic [DW-1:0] rseq [4] = '{8'h44, 8'h33, 8'h22, 8'h11};

    repeat (2) @(negedge clk_i);
    chk("rst_count", 32'(a_count), 0);
    chk("rst_status", {28'd0, a_empty, a_full, a_af, a_ae}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    chk("rst_errs", {28'd0, a_ovf, a_unf, b_ovf, b_unf}, 32'd0);
    chk("rst_valid", {30'd0, a_valid, b_valid}, 32'd0);
    chk("rst_b_data", 32'(b_data), 0);
    reset_ni = 1'b1;

    // LIFO ordering
    for (int i = 0; i < 4; i++) apply(1, seq[i], 0, 0, 0, 0);
    idle(0);
    chk("lifo_full", 32'(a_full), 1);
    chk("lifo_count4", 32'(a_count), 4);
    for (int i = 0; i < 4; i++) begin
      apply(0, '0, 1, 0, 0, 0);
      chk("lifo_pop", 32'(a_data), 32'(rseq[i]));
    end
    idle(0);
    chk("lifo_empty", 32'(a_empty), 1);
    chk("oreg_valid", 32'(b_valid), 1);
    chk("oreg_data", 32'(b_data), 32'h11);
    idle(0);
    chk("oreg_valid_drop", 32'(b_valid), 0);
    chk("oreg_data_hold", 32'(b_data), 32'h11);

    // FIFO ordering with pointer wrap
    for (int i = 0; i < 4; i++) apply(1, seq[i], 0, 1, 0, 0);
    for (int i = 0; i < 4; i++) begin
      apply(0, '0, 1, 1, 0, 0);
      chk("fifo_pop", 32'(a_data), 32'(seq[i]));
    end
    apply(1, 8'h55, 0, 1, 0, 0);
    apply(0, '0, 1, 1, 0, 0);
    chk("fifo_wrap_pop", 32'(a_data), 32'h55);

    // Mixed mode
    apply(1, 8'hA0, 0, 1, 0, 0);
    apply(1, 8'hA1, 0, 1, 0, 0);
    apply(1, 8'hA2, 0, 1, 0, 0);
    apply(0, '0, 1, 1, 0, 0);
    chk("mixed_fifo_pop", 32'(a_data), 32'hA0);
    apply(0, '0, 1, 0, 0, 0);
    chk("mixed_lifo_pop", 32'(a_data), 32'hA2);
    idle(1);
    chk("mixed_count", 32'(a_count), 1);
    chk("mixed_remaining", 32'(a_data), 32'hA1);
    apply(0, '0, 1, 1, 0, 0);

    // Simultaneous push/pop when full, overflow, clear, flush
    for (int i = 0; i < 4; i++) apply(1, seq[i], 0, 0, 0, 0);
    apply(1, 8'h99, 1, 0, 0, 0);
    chk("full_pushpop_data", 32'(a_data), 32'h44);
    idle(0);
    chk("full_pushpop_count", 32'(a_count), 4);
    chk("full_pushpop_top", 32'(a_data), 32'h99);
    apply(1, 8'h77, 0, 0, 0, 0);
    idle(0);
    chk("overflow_set", 32'(a_ovf), 1);
    chk("overflow_top_kept", 32'(a_data), 32'h99);
    chk("overflow_count", 32'(a_count), 4);
    apply(0, '0, 0, 0, 0, 1);
    idle(0);
    chk("err_clear", {30'd0, a_ovf, a_unf}, 32'd0);
    apply(0, '0, 1, 0, 0, 0);
    apply(0, '0, 0, 0, 1, 0);
    idle(0);
    chk("flush_count", 32'(a_count), 0);
    chk("flush_empty", 32'(a_empty), 1);

    // Simultaneous push/pop when empty
    apply(1, 8'h5A, 1, 0, 0, 0);
    chk("empty_pushpop_valid", 32'(a_valid), 0);
    idle(0);
    chk("empty_pushpop_unf", 32'(a_unf), 1);
    chk("empty_pushpop_count", 32'(a_count), 1);
    apply(0, '0, 0, 0, 1, 1);

    // Randomized traffic, alternating fill-biased and drain-biased phases
    for (int i = 0; i < 1500; i++) begin
      int pp = ((i / 60) % 2 == 0) ? 70 : 30;
      apply($urandom_range(99) < pp, 8'($urandom), $urandom_range(99) < 100 - pp,
            1'($urandom), $urandom_range(99) < 2, $urandom_range(99) < 4);
    end

    // Asynchronous reset mid-burst at count 2
    apply(0, '0, 0, 0, 1, 1);
    apply(0, '0, 1, 0, 0, 0);
    apply(1, 8'hC1, 0, 0, 0, 0);
    apply(1, 8'hC2, 1, 1, 0, 0);
    apply(1, 8'hC3, 0, 0, 0, 0);
    @(negedge clk_i);
    push_i = 1'b1; push_data_i = 8'hC4; pop_i = 1'b0; flush_i = 1'b0; err_clear_i = 1'b0;
    #1;
    chk("pre_reset_count", 32'(a_count), 2);
    chk("pre_reset_unf", 32'(a_unf), 1);
    #2;
    reset_ni = 1'b0;
    #1;
    model_reset();
    chk("async_rst_count", 32'(a_count), 0);
    chk("async_rst_status", {28'd0, a_empty, a_full, a_af, a_ae}, {28'd0, 1'b1, 1'b0, 1'b0, 1'b1});
    chk("async_rst_errs", {28'd0, a_ovf, a_unf, b_ovf, b_unf}, 32'd0);
    chk("async_rst_valid", {30'd0, a_valid, b_valid}, 32'd0);
    chk("async_rst_b_data", 32'(b_data), 0);
    push_i = 1'b0;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    reset_ni = 1'b1;
    apply(0, '0, 1, 0, 0, 0);
    idle(0);
    chk("post_reset_unf", 32'(a_unf), 1);
    chk("post_reset_count", 32'(a_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/lifo_deque.md
# lifo_deque

Parametrised successor to the team's single-mode LIFO: a bounded buffer whose pop end is chosen per cycle by `mode_i`, popping newest-first (LIFO) or oldest-first (FIFO) from the same storage. Adds occupancy count, almost-full/almost-empty thresholds, flush, sticky overflow/underflow flags, defined simultaneous push/pop behaviour and an optional output register. It sits between a producer and consumer that need stack or queue ordering, or both, at runtime.

## Interface
- `DEPTH`, 32: entries; power of two, ≥ 2.
- `DATA_WIDTH`, 32: word width.
- `ALMOST_FULL`, DEPTH-2: `almost_full_o` asserts when count ≥ this value; range 1..DEPTH.
- `ALMOST_EMPTY`, 2: `almost_empty_o` asserts when count ≤ this value; range 0..DEPTH-1.
- `OUTPUT_REGISTER`, 0: 0 gives combinational pop data; 1 registers pop data one cycle after accept.
- `clk_i` in 1: single clock; all state changes on the rising edge.
- `reset_ni` in 1: asynchronous, active-low reset.
- `mode_i` in 1: 0 = LIFO (pop the newest word), 1 = FIFO (pop the oldest word); sampled every cycle.
- `flush_i` in 1: empties the buffer.
- `push_i` in 1: push request.
- `push_data_i` in DATA_WIDTH: push word.
- `pop_i` in 1: pop request.
- `pop_data_o` out DATA_WIDTH: popped word.
- `pop_valid_o` out 1: `pop_data_o` carries an accepted pop.
- `empty_o`, `full_o` out 1: count == 0; count == DEPTH.
- `almost_empty_o`, `almost_full_o` out 1: threshold flags.
- `count_o` out $clog2(DEPTH)+1: current occupancy.
- `err_clear_i` in 1: clears both sticky error flags.
- `overflow_o`, `underflow_o` out 1: sticky error flags.

## Operation
- State: `wr_ptr` and `rd_ptr` ($clog2(DEPTH) bits, wrap mod DEPTH) and `count`.
- Valid words occupy rd_ptr .. wr_ptr-1 (mod DEPTH).
- Push writes `mem[wr_ptr]`, then wr_ptr+1.
- FIFO pop reads `mem[rd_ptr]`, then rd_ptr+1.
- LIFO pop reads `mem[wr_ptr-1]`, then wr_ptr-1.
- Mode may change on any cycle. Contents are kept; ordering follows the current `mode_i`.
- Acceptance, in priority order:
  - `flush_i`: pointers and count go to 0; push and pop are ignored; no error flags are set.
  - push and pop with count > 0: both are accepted and count is unchanged, even when full.
    - FIFO: write `mem[wr_ptr]`, read `mem[rd_ptr]`, both pointers +1.
    - LIFO: the pop returns the current top, `mem[wr_ptr-1]` is overwritten with `push_data_i`, pointers unchanged.
  - push and pop with count == 0: the push is accepted, the pop is rejected and `underflow_o` is set.
  - push alone when full: rejected, no state change, `overflow_o` is set.
  - pop alone when empty: rejected, `underflow_o` is set.
- Sticky flags: setting wins over `err_clear_i` in the same cycle. `flush_i` does not clear the flags.
- Status outputs are combinational decodes of the registered count.
- Reset values:
  - pointers 0, `count_o` 0, `empty_o` 1, `full_o` 0, `almost_full_o` 0, `almost_empty_o` 1.
  - both error flags 0, `pop_valid_o` 0.
  - `pop_data_o` 0 when OUTPUT_REGISTER=1; otherwise it reflects memory (unspecified) and is don't-care while `empty_o`=1.
- The memory has no reset. Reset mid-operation discards all contents immediately (asynchronous reset).

## Timing
- OUTPUT_REGISTER=0:
  - `pop_data_o` is combinational and shows the word the current `mode_i` would pop.
  - `pop_valid_o` = pop accepted, in the same cycle.
- OUTPUT_REGISTER=1:
  - the popped word is registered at the accept edge.
  - `pop_data_o` and `pop_valid_o` are valid the following cycle.
  - `pop_valid_o` is high one cycle per accepted pop, and `pop_data_o` holds its value otherwise.
- There is no write-to-read bypass: a pushed word can first be popped on the cycle after its push.
- Count and flags update at the accept edge: push at edge N means `count_o` rises after edge N.

## Structure
- Package `lifo_pkg`:
  - `typedef enum logic {MODE_LIFO=1'b0, MODE_FIFO=1'b1} lifo_mode_e`.
  - function `cnt_width(depth)` returning $clog2(depth)+1.
- One sub-module, `lifo_deque_ram`: DATA_WIDTH×DEPTH, one synchronous write port, one asynchronous read port, no reset.
- Pointer, count and flag logic stay in the top module.

## Test plan
- All cases use DEPTH=4, DATA_WIDTH=8.
- LIFO: push 0x11,0x22,0x33,0x44 → `full_o`=1, `count_o`=4; four pops → 0x44,0x33,0x22,0x11, then `empty_o`=1.
- FIFO: same pushes → pops return 0x11,0x22,0x33,0x44; pointers wrap, and a following push 0x55 then pop returns 0x55.
- Mixed mode: push 0xA0,0xA1,0xA2; FIFO pop → 0xA0; LIFO pop → 0xA2; `count_o`=1, the remaining word is 0xA1.
- Simultaneous push and pop:
  - when full in LIFO with push 0x99 → pop returns 0x44, top becomes 0x99, `count_o` stays 4.
  - when empty → push accepted, `underflow_o`=1, `count_o`=1.
- Errors and flush:
  - push when full → `overflow_o`=1, contents unchanged.
  - `err_clear_i` with no new error → flags 0.
  - `flush_i` when count=3 → `count_o`=0, `empty_o`=1.
  - with OUTPUT_REGISTER=1, pop data arrives one cycle late with a one-cycle `pop_valid_o`.
- Reset: drive `reset_ni` low asynchronously mid-burst when count=2 → outputs take their reset values at once; after release, first pop → `underflow_o`=1.
